alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Command queue and issue controller sitting directly upstream of the team's 4-bit combinational ALU (2-bit op select, two 4-bit operands, 4-bit result). It accepts op/operand commands over a valid/ready handshake, buffers them in a small FIFO, and drives them one at a time into the ALU from registers. It captures the ALU result one cycle later and presents it on a valid/ready result port. This gives the combinational ALU a clocked, back-pressured front end.

## Interface
- DEPTH, 4, command FIFO entries; power of two, 2..16
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; equals (count != DEPTH)
- cmd_op  in  2  ALU op: 00 xor, 01 or, 10 and, 11 not-b
- cmd_b  in  4  operand b
- cmd_c  in  4  operand c
- alu_sel  out  2  registered op to ALU
- alu_b  out  4  registered operand b to ALU
- alu_c  out  4  registered operand c to ALU
- alu_s  in  4  ALU combinational result
- res_valid  out  1  result held
- res_ready  in  1  consumer accepts result
- res_data  out  4  captured result
- res_zero  out  1  res_data == 0, registered with res_data
- busy  out  1  FSM not IDLE or FIFO non-empty

## Operation
- Push on cmd_valid && cmd_ready at a clock edge; {op,b,c} written at tail.
- cmd_ready depends only on current count. When FIFO is full, a push is refused even if a pop occurs in the same cycle.
- FSM states: IDLE, DRIVE, WAIT_ACK.
- IDLE, FIFO non-empty: load alu_sel/alu_b/alu_c from head, pop, go to DRIVE. Empty: stay.
- DRIVE, always one cycle: res_data <= alu_s, res_zero <= (alu_s == 0), res_valid <= 1; go to WAIT_ACK.
- WAIT_ACK with res_ready:
  - res_valid <= 0.
  - If FIFO non-empty, load and pop the next head and go to DRIVE; otherwise go to IDLE.
- WAIT_ACK without res_ready: hold res_data, res_zero and res_valid stable.
- alu_* outputs hold their last issued values between commands.
- Push and pop in the same cycle (not full): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits wide.
- res_ready while res_valid == 0 is ignored.
- Operand widths fixed at 4 bits. No arithmetic is performed here; the result is taken verbatim from alu_s.

## Timing
- Reset, asynchronous, takes effect immediately:
  - FSM IDLE; FIFO empty; pointers 0.
  - cmd_ready 1; res_valid 0; res_data 0; res_zero 0.
  - alu_sel 00; alu_b 0; alu_c 0; busy 0.
- Reset mid-operation discards the queued command, the in-flight command and the held result.
- Latency: command accepted at edge k into an empty, idle block → alu_* valid after edge k+1 → res_valid high after edge k+2.
- Throughput: one result per 2 cycles with res_ready tied high.
- alu_s is sampled only at the DRIVE edge. The ALU must settle within one clock period.
- A push is never visible to the issue logic in the cycle it is written. IDLE sees it at the next edge.

## Configuration
- ALU_ISSUE_CNT_EN defined:
  - Adds output done_cnt [7:0], counting completed result handshakes (res_valid && res_ready).
  - Reset value 0; wraps 255 → 0.
- ALU_ISSUE_CNT_EN undefined: port and counter absent; all other behaviour identical.

## Test plan
- Bench connects the 4-bit ALU model to alu_*/alu_s.
- Reset, then op 00, b=1010, c=0110, res_ready=1 → res_valid after 2 edges, res_data=1100, res_zero=0, then busy=0.
- Ops 01 (0101,1010), 10 (0101,1010), 11 (b=0011) pushed back-to-back, res_ready=1 → results 1111, 0000 with res_zero=1, 1100, in order, spaced 2 cycles apart.
- res_ready=0, push continuously:
  - Exactly DEPTH+1=5 commands accepted, then cmd_ready=0.
  - res_data held stable.
  - Raising res_ready drains 5 results in order; cmd_ready returns high after the first pop.
- Full FIFO, cmd_valid=1 with a pop in the same cycle → push refused; count goes DEPTH → DEPTH-1; the refused command is accepted at the next edge.
- Assert rst_n low with 3 queued commands and res_valid=1 → all outputs at reset values immediately, no further results after release. With ALU_ISSUE_CNT_EN, done_cnt=0.
- ALU_ISSUE_CNT_EN: complete 257 results → done_cnt=1.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Command and result handshake bundle for alu_issue_ctrl.
// master: command producer / result consumer. slave: the issue controller.
interface alu_issue_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_b;
  logic [3:0] cmd_c;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_b, cmd_c, res_ready,
    input  cmd_ready, res_valid, res_data, res_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_b, cmd_c, res_ready,
    output cmd_ready, res_valid, res_data, res_zero
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: command FIFO plus issue FSM in front of a 4-bit
// combinational ALU. Commands are queued, driven into the ALU from
// registers one at a time, and the ALU result is captured one cycle later
// and held on a valid/ready result port.
// Optional feature macro: ALU_ISSUE_CNT_EN adds done_cnt[7:0], a wrapping
// count of completed result handshakes.
module alu_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_issue_ctrl_if.slave      bus,
  output logic [1:0]           alu_sel,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_c,
  input  logic [3:0]           alu_s,
  output logic                 busy
`ifdef ALU_ISSUE_CNT_EN
  ,
  output logic [7:0]           done_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t        r_state;
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic [1:0]    r_alu_sel;
  logic [3:0]    r_alu_b;
  logic [3:0]    r_alu_c;
  logic          r_res_valid;
  logic [3:0]    r_res_data;
  logic          r_res_zero;

  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [9:0]    w_head;

  // cmd_ready looks only at the registered count, so a pop in the same
  // cycle never lets a push into a full FIFO.
  assign w_empty       = (r_count == '0);
  assign bus.cmd_ready = (r_count != (AW+1)'(DEPTH));
  assign w_push        = bus.cmd_valid && bus.cmd_ready;
  // The FSM pops whenever it loads a new command into the ALU registers.
  assign w_pop         = !w_empty &&
                         ((r_state == IDLE) || ((r_state == WAIT_ACK) && bus.res_ready));
  assign w_head        = r_mem[r_rd_ptr];

  // Command storage; contents are don't-care until counted, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.cmd_op, bus.cmd_b, bus.cmd_c};
    end
  end

  // FIFO pointers (wrap naturally, DEPTH is a power of two) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue FSM: load ALU operands, capture the ALU result, wait for the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_alu_sel   <= '0;
      r_alu_b     <= '0;
      r_alu_c     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            {r_alu_sel, r_alu_b, r_alu_c} <= w_head;
            r_state <= DRIVE;
          end
        end
        DRIVE: begin
          r_res_data  <= alu_s;
          r_res_zero  <= (alu_s == 4'd0);
          r_res_valid <= 1'b1;
          r_state     <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            if (!w_empty) begin
              {r_alu_sel, r_alu_b, r_alu_c} <= w_head;
              r_state <= DRIVE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_CNT_EN
  logic [7:0] r_done_cnt;

  // Completed result handshakes, wrapping at 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_cnt <= '0;
    end else if (r_res_valid && bus.res_ready) begin
      r_done_cnt <= r_done_cnt + 8'd1;
    end
  end

  assign done_cnt = r_done_cnt;
`endif

  assign alu_sel       = r_alu_sel;
  assign alu_b         = r_alu_b;
  assign alu_c         = r_alu_c;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_zero  = r_res_zero;
  assign busy          = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed, table-driven bench for alu_issue_ctrl with a 4-bit ALU model
// attached to alu_*/alu_s.
module tb_alu_issue_ctrl;
  logic       clk;
  logic       rst_n;
  logic [1:0] alu_sel;
  logic [3:0] alu_b;
  logic [3:0] alu_c;
  logic [3:0] alu_s;
  logic       busy;
`ifdef ALU_ISSUE_CNT_EN
  logic [7:0] done_cnt;
`endif

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_sel  (alu_sel),
    .alu_b    (alu_b),
    .alu_c    (alu_c),
    .alu_s    (alu_s),
    .busy     (busy)
`ifdef ALU_ISSUE_CNT_EN
    ,
    .done_cnt (done_cnt)
`endif
  );

  // 4-bit combinational ALU model
  always_comb begin
    case (alu_sel)
      2'b00:   alu_s = alu_b ^ alu_c;
      2'b01:   alu_s = alu_b | alu_c;
      2'b10:   alu_s = alu_b & alu_c;
      default: alu_s = ~alu_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] op;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] res;
    logic       zero;
  } vec_t;

  typedef struct {
    logic [3:0] d;
    logic       z;
    int         cyc;
  } res_t;

  res_t rq[$];

  // Record every result handshake (sampled on the falling edge before it).
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      rq.push_back('{d: bus.res_data, z: bus.res_zero, cyc: cyc});
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command and hold it until accepted (bounded).
  task automatic push(input vec_t v);
    bit done = 0;
    bus.cmd_op    = v.op;
    bus.cmd_b     = v.b;
    bus.cmd_c     = v.c;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.cmd_ready) done = 1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_rq(input int n, input int lim, input string name);
    for (int i = 0; i < lim && rq.size() < n; i++) tick();
    chk(name, rq.size(), n);
  endtask

  vec_t tbl1[6];
  vec_t tbl2[6];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    bit acc;

    // single-command vectors {op, b, c, result, zero}
    tbl1[0] = '{2'b00, 4'b1010, 4'b0110, 4'b1100, 1'b0};
    tbl1[1] = '{2'b01, 4'b0101, 4'b1010, 4'b1111, 1'b0};
    tbl1[2] = '{2'b10, 4'b0101, 4'b1010, 4'b0000, 1'b1};
    tbl1[3] = '{2'b11, 4'b0011, 4'b0000, 4'b1100, 1'b0};
    tbl1[4] = '{2'b11, 4'b0000, 4'b0101, 4'b1111, 1'b0};
    tbl1[5] = '{2'b10, 4'b1111, 4'b1001, 4'b1001, 1'b0};
    // fill/drain vectors
    tbl2[0] = '{2'b00, 4'b0001, 4'b0011, 4'b0010, 1'b0};
    tbl2[1] = '{2'b01, 4'b0100, 4'b0010, 4'b0110, 1'b0};
    tbl2[2] = '{2'b10, 4'b1100, 4'b1010, 4'b1000, 1'b0};
    tbl2[3] = '{2'b11, 4'b1111, 4'b0000, 4'b0000, 1'b1};
    tbl2[4] = '{2'b00, 4'b0111, 4'b0111, 4'b0000, 1'b1};
    tbl2[5] = '{2'b01, 4'b1000, 4'b0001, 4'b1001, 1'b0};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_b     = '0;
    bus.cmd_c     = '0;
    bus.res_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) tick();

    // reset state
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data",  bus.res_data, 0);
    chk("rst_res_zero",  bus.res_zero, 0);
    chk("rst_alu", {alu_sel, alu_b, alu_c}, 0);
    chk("rst_busy", busy, 0);
`ifdef ALU_ISSUE_CNT_EN
    chk("rst_done_cnt", done_cnt, 0);
`endif
    rst_n = 1'b1;
    tick();

    // single commands: exact latency k+1 (alu_*), k+2 (res_valid)
    bus.res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("lat_ready", bus.cmd_ready, 1);
      bus.cmd_op = tbl1[i].op; bus.cmd_b = tbl1[i].b; bus.cmd_c = tbl1[i].c;
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      chk("lat_k_valid", bus.res_valid, 0);
      tick();
      chk("lat_k1_alu", {alu_sel, alu_b, alu_c}, {tbl1[i].op, tbl1[i].b, tbl1[i].c});
      chk("lat_k1_valid", bus.res_valid, 0);
      tick();
      chk("lat_k2_valid", bus.res_valid, 1);
      chk("lat_k2_data", bus.res_data, tbl1[i].res);
      chk("lat_k2_zero", bus.res_zero, tbl1[i].zero);
      tick();
      chk("lat_k3_valid", bus.res_valid, 0);
      chk("lat_k3_busy", busy, 0);
      $display("vec %0d op=%b b=%b c=%b res=%b", i, tbl1[i].op, tbl1[i].b, tbl1[i].c, tbl1[i].res);
    end

    // back-to-back 01, 10, 11: results in order, 2 cycles apart
    rq.delete();
    for (int i = 1; i < 4; i++) push(tbl1[i]);
    wait_rq(3, 40, "b2b_count");
    if (rq.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("b2b_data", rq[i].d, tbl1[i+1].res);
        chk("b2b_zero", rq[i].z, tbl1[i+1].zero);
        $display("b2b result %0d data=%b zero=%b cyc=%0d", i, rq[i].d, rq[i].z, rq[i].cyc);
      end
      chk("b2b_gap0", rq[1].cyc - rq[0].cyc, 2);
      chk("b2b_gap1", rq[2].cyc - rq[1].cyc, 2);
    end
    repeat (3) tick();

    // fill with res_ready low: exactly DEPTH+1 accepted
    bus.res_ready = 1'b0;
    rq.delete();
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      bus.cmd_op = tbl2[idx < 5 ? idx : 5].op;
      bus.cmd_b  = tbl2[idx < 5 ? idx : 5].b;
      bus.cmd_c  = tbl2[idx < 5 ? idx : 5].c;
      bus.cmd_valid = 1'b1;
      acc = bus.cmd_ready;
      tick();
      if (acc) idx++;
    end
    chk("fill_accepted", idx, 5);
    chk("fill_ready_low", bus.cmd_ready, 0);
    for (int k = 0; k < 3; k++) begin
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_data", bus.res_data, tbl2[0].res);
      tick();
    end
    // full FIFO, pop and push attempt in the same cycle: push refused
    bus.cmd_op = tbl2[5].op; bus.cmd_b = tbl2[5].b; bus.cmd_c = tbl2[5].c;
    bus.res_ready = 1'b1;
    chk("full_ready_before_pop", bus.cmd_ready, 0);
    tick();
    chk("ready_after_pop", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("refused_accepted_next", bus.cmd_ready, 0);
    wait_rq(6, 60, "drain_count");
    if (rq.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("drain_data", rq[i].d, tbl2[i].res);
        chk("drain_zero", rq[i].z, tbl2[i].zero);
        $display("drain result %0d data=%b zero=%b", i, rq[i].d, rq[i].z);
      end
    end
    repeat (3) tick();
    chk("drain_busy", busy, 0);

    // async reset with 3 queued + 1 held result
    bus.res_ready = 1'b0;
    rq.delete();
    for (int i = 0; i < 4; i++) push(tbl1[i]);
    for (int k = 0; k < 10 && !bus.res_valid; k++) tick();
    chk("pre_rst_valid", bus.res_valid, 1);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cmd_ready", bus.cmd_ready, 1);
    chk("arst_res_valid", bus.res_valid, 0);
    chk("arst_res_data",  bus.res_data, 0);
    chk("arst_res_zero",  bus.res_zero, 0);
    chk("arst_alu", {alu_sel, alu_b, alu_c}, 0);
    chk("arst_busy", busy, 0);
`ifdef ALU_ISSUE_CNT_EN
    chk("arst_done_cnt", done_cnt, 0);
`endif
    tick();
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    repeat (20) tick();
    chk("post_rst_results", rq.size(), 0);
    chk("post_rst_busy", busy, 0);

`ifdef ALU_ISSUE_CNT_EN
    // 257 completions wrap the counter to 1
    rq.delete();
    for (int i = 0; i < 257; i++) push(tbl1[i % 6]);
    wait_rq(257, 3000, "cnt_results");
    tick();
    chk("done_cnt_wrap", done_cnt, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
